// File: rtl/seg_display_arbiter_if.sv
// seg_display_arbiter_if
// Purpose: groups the request/data inputs and display/grant outputs of the
//          seven-segment display arbiter into one bundle.
// Signals:
//   tick          slow-divider enable, one clk wide
//   req[2:0]      client requests (0=balance, 1=PIN echo, 2=status)
//   data0..data2  four BCD nibbles per client, nibble 0 = bits[3:0]
//   gnt[2:0]      one-hot grant
//   busy          a grant is held
//   an[3:0]       active-low digit enable
//   digit[3:0]    BCD nibble for the enabled digit
//   dp            active-low decimal point
//   timeout       one-cycle pulse on a forced release
// Modports: master drives requests/data, slave is the arbiter.
interface seg_display_arbiter_if;
    logic        tick;
    logic [2:0]  req;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [15:0] data2;
    logic [2:0]  gnt;
    logic        busy;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        dp;
    logic        timeout;

    modport master (
        output tick, req, data0, data1, data2,
        input  gnt, busy, an, digit, dp, timeout
    );

    modport slave (
        input  tick, req, data0, data1, data2,
        output gnt, busy, an, digit, dp, timeout
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Purpose: round-robin arbiter giving one of three clients ownership of a
//          4-digit multiplexed seven-segment display. The owner's BCD data is
//          scanned out one digit per SCAN_DIV clocks. A grant is held for at
//          least MIN_HOLD ticks; with SEG_ARB_TIMEOUT_EN defined an owner is
//          forced off after MAX_HOLD ticks when another client is waiting.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   seg_display_arbiter_if.slave (tick, req, data0..2 in;
//         gnt, busy, an, digit, dp, timeout out)
// Parameters: SCAN_DIV, MIN_HOLD, MAX_HOLD (MAX_HOLD > MIN_HOLD).
// Optional feature macro: SEG_ARB_TIMEOUT_EN (forced release + dp marker).
//
// state | meaning
// IDLE  | no owner, arbitrate on any req
// OWNED | grant held, display shows owner's data
// GAP   | one blank cycle between owners
module seg_display_arbiter #(
    parameter int SCAN_DIV = 100000,
    parameter int MIN_HOLD = 40,
    parameter int MAX_HOLD = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_display_arbiter_if.slave  bus
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] MIN_H     = HW'(MIN_HOLD);
    localparam logic [HW-1:0] MAX_H     = HW'(MAX_HOLD);

    typedef enum logic [1:0] {S_IDLE, S_OWNED, S_GAP} state_t;

    state_t         r_state;
    logic [2:0]     r_gnt;
    logic           r_busy;
    logic [1:0]     r_owner;
    logic [1:0]     r_last;
    logic [HW-1:0]  r_hold;
    logic [SW-1:0]  r_scan;
    logic [1:0]     r_idx;
    logic [15:0]    r_disp;

    logic [1:0]     w_c0, w_c1, w_c2;
    logic [1:0]     w_win;
    logic [15:0]    w_win_data;
    logic [15:0]    w_own_data;
    logic [HW-1:0]  w_hold_inc;
    logic           w_release;
    logic           w_owned;

    // Search order starts just after the last grantee, so the previous
    // owner is always tried last.
    always_comb begin
        w_c0 = 2'd0;
        w_c1 = 2'd1;
        w_c2 = 2'd2;
        case (r_last)
            2'd0: begin w_c0 = 2'd1; w_c1 = 2'd2; w_c2 = 2'd0; end
            2'd1: begin w_c0 = 2'd2; w_c1 = 2'd0; w_c2 = 2'd1; end
            default: begin w_c0 = 2'd0; w_c1 = 2'd1; w_c2 = 2'd2; end
        endcase
        if (bus.req[w_c0])
            w_win = w_c0;
        else if (bus.req[w_c1])
            w_win = w_c1;
        else
            w_win = w_c2;
    end

    always_comb begin
        case (w_win)
            2'd0:    w_win_data = bus.data0;
            2'd1:    w_win_data = bus.data1;
            default: w_win_data = bus.data2;
        endcase
        case (r_owner)
            2'd0:    w_own_data = bus.data0;
            2'd1:    w_own_data = bus.data1;
            default: w_own_data = bus.data2;
        endcase
    end

    // Release is judged on the post-tick count so a tick and a req drop in
    // the same cycle release together.
    assign w_hold_inc = (bus.tick && (r_hold != MAX_H)) ? r_hold + 1'b1 : r_hold;
    assign w_release  = !bus.req[r_owner] && (w_hold_inc >= MIN_H);
    assign w_owned    = (r_state == S_OWNED);

`ifdef SEG_ARB_TIMEOUT_EN
    logic r_timeout;
    logic r_forced_prev;   // last release was forced
    logic r_forced_own;    // current owner was granted right after a forced release
    logic w_force;

    // r_gnt is the owner's one-hot while OWNED, so this masks out the owner.
    assign w_force = !w_release && (w_hold_inc == MAX_H) && (|(bus.req & ~r_gnt));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= 3'b000;
            r_busy  <= 1'b0;
            r_owner <= 2'd0;
            r_last  <= 2'd2;
            r_hold  <= '0;
            r_scan  <= '0;
            r_idx   <= 2'd0;
            r_disp  <= 16'h0000;
`ifdef SEG_ARB_TIMEOUT_EN
            r_timeout     <= 1'b0;
            r_forced_prev <= 1'b0;
            r_forced_own  <= 1'b0;
`endif
        end else begin
            if (r_scan == SCAN_LAST) begin
                r_scan <= '0;
                r_idx  <= r_idx + 2'd1;
            end else begin
                r_scan <= r_scan + 1'b1;
            end
`ifdef SEG_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (|bus.req) begin
                        r_state <= S_OWNED;
                        r_gnt   <= 3'b001 << w_win;
                        r_busy  <= 1'b1;
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_hold  <= '0;
                        r_disp  <= w_win_data;
`ifdef SEG_ARB_TIMEOUT_EN
                        r_forced_own <= r_forced_prev;
`endif
                    end
                end
                S_OWNED: begin
                    r_disp <= w_own_data;
                    r_hold <= w_hold_inc;
                    if (w_release) begin
                        r_state <= S_GAP;
                        r_gnt   <= 3'b000;
                        r_busy  <= 1'b0;
`ifdef SEG_ARB_TIMEOUT_EN
                        r_forced_prev <= 1'b0;
                    end else if (w_force) begin
                        r_state       <= S_GAP;
                        r_gnt         <= 3'b000;
                        r_busy        <= 1'b0;
                        r_timeout     <= 1'b1;
                        r_forced_prev <= 1'b1;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.busy  = r_busy;
    assign bus.an    = w_owned ? ~(4'b0001 << r_idx) : 4'b1111;
    assign bus.digit = w_owned ? r_disp[{r_idx, 2'b00} +: 4] : 4'h0;

`ifdef SEG_ARB_TIMEOUT_EN
    assign bus.dp      = !(w_owned && r_forced_own && (r_idx == 2'd3));
    assign bus.timeout = r_timeout;
`else
    assign bus.dp      = 1'b1;
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: doc/seg_display_arbiter.md
SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 Parameter SCAN_DIV, default 100000: clk cycles per digit scan slot.
REQ-002 Parameter MIN_HOLD, default 40: minimum tick count a grant is held.
REQ-003 Parameter MAX_HOLD, default 200: tick limit for the timeout feature; MAX_HOLD > MIN_HOLD.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 tick  in  1  one-cycle enable from the slow clock divider; holds are counted in ticks.
REQ-007 req  in  3  request per display client: 0=balance, 1=PIN echo, 2=status message.
REQ-008 data0, data1, data2  in  16 each  four BCD nibbles per client; nibble 0 is bits[3:0] (rightmost digit).
REQ-009 gnt  out  3  registered one-hot grant.
REQ-010 busy  out  1  high while any grant is held.
REQ-011 an  out  4  active-low digit enable.
REQ-012 digit  out  4  BCD nibble for the enabled digit.
REQ-013 dp  out  1  active-low decimal point.
REQ-014 timeout  out  1  one-cycle pulse on a forced release.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, OWNED and GAP.
- IDLE: any req bit set -> OWNED.
- OWNED: release condition met -> GAP.
- GAP: lasts exactly 1 cycle, then -> IDLE.
REQ-016 Arbitration SHALL be round-robin.
- The search starts at the index after the last grantee.
- The last grantee is 2 after reset, so req[0] wins first.
REQ-017 gnt SHALL assert on the clock edge that samples the winning req in IDLE; one-cycle arbitration latency.
REQ-018 While in OWNED, disp_bcd SHALL re-latch the owner's data every cycle, so the display shows that data one cycle late.
REQ-019 hold_cnt SHALL clear on grant, increment on each tick while OWNED, and saturate at MAX_HOLD.
REQ-020 Release SHALL occur when the owner's req is low and hold_cnt >= MIN_HOLD.
- An early req drop keeps the grant and the last latched data until MIN_HOLD is reached.
REQ-021 There SHALL be no preemption, except as defined in REQ-029.
REQ-022 In GAP and IDLE, gnt SHALL be 0 and busy SHALL be 0.
REQ-023 In GAP, a pending req from the previous owner SHALL lose to any other pending req.
REQ-024 The scan counter SHALL count 0..SCAN_DIV-1 in every state and advance the digit index 0,1,2,3,0 (wrap) on terminal count.
REQ-025 While OWNED, an SHALL drive 0 on bit[idx] only, and digit SHALL be disp_bcd nibble idx.
REQ-026 While not OWNED, an SHALL be 4'b1111 and digit SHALL be 4'h0.
REQ-027 A tick and a req drop in the same cycle SHALL be evaluated against the incremented hold_cnt.

Reset
REQ-028 On rst, outputs and state SHALL take these values on the same edge, overriding all other inputs:
- state=IDLE, gnt=0, busy=0, an=4'b1111, digit=0, dp=1, timeout=0.
- hold_cnt=0, scan counter=0, idx=0, last grantee=2, disp_bcd=0.
- A reset mid-grant drops gnt with no GAP cycle.

Configuration
REQ-029 With SEG_ARB_TIMEOUT_EN defined:
- OWNED SHALL go to GAP when hold_cnt == MAX_HOLD and another req bit is set, regardless of the owner's req.
- timeout SHALL pulse for 1 cycle on entry to GAP.
- dp SHALL be 0 on digit 3 while the current owner was granted directly after a forced release.
REQ-030 Without SEG_ARB_TIMEOUT_EN, timeout SHALL be constant 0, dp SHALL be constant 1, and the timeout logic SHALL be absent.

Verification
REQ-031 The bench SHALL cover these scenarios (SCAN_DIV=4, MIN_HOLD=3, MAX_HOLD=6):
- req=3'b001, data0=16'h1234 -> gnt=001 next cycle; an cycles 1110,1101,1011,0111 with digit 4,3,2,1, each slot 4 clks.
- req0 drops after 1 tick -> gnt held until the 3rd tick; req0 high again in GAP -> still re-granted.
- req=3'b111 persistently, each dropped after MIN_HOLD -> grant order 0,1,2,0.
- rst asserted while gnt=010 -> next edge gnt=000, an=1111; req=011 after reset -> gnt=001.
- SEG_ARB_TIMEOUT_EN defined, req0 held, req1 raised -> timeout pulse at tick 6, GAP, gnt=010, dp=0 on digit 3; without the macro, gnt stays 001.
